rf_fade_controller: RTL and testbench

Downstream consumer of the watchdog timer's warning/triggered outputs. It gates the AM transmitter's output gain and RF enable.
- Output gain tracks the host-requested gain.
- A watchdog warning attenuates the gain.
- A watchdog trigger ramps the carrier down to silence instead of cutting it abruptly, then holds it muted until the host explicitly clears the latched fault.
- Sits between the watchdog and the modulator amplitude multiplier.

---
 rtl/am_radio_safety_pkg.sv | 17 +
 rtl/gain_ramp_step.sv | 21 ++
 rtl/rf_fade_controller.sv | 144 ++++++++++++++
 tb/tb_rf_fade_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/am_radio_safety_pkg.sv
// Shared types and defaults for the AM transmitter safety path
// (watchdog -> fade controller -> modulator).
package am_radio_safety_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_t;

    localparam int          GAIN_W_DEF     = 16;
    localparam int unsigned RAMP_STEP_DEF  = 32'h0000_1000;
    localparam int unsigned RAMP_DIV_DEF   = 4;
    localparam int unsigned WARN_SHIFT_DEF = 1;

endpackage

// File: rtl/gain_ramp_step.sv
// One ramp step: saturating add clamped to a target, and subtract floored at zero.
module gain_ramp_step #(
    parameter int GAIN_W = 16
) (
    input  logic [GAIN_W-1:0] gain_i,
    input  logic [GAIN_W-1:0] target_i,
    input  logic [GAIN_W-1:0] step_i,
    output logic [GAIN_W-1:0] up_o,
    output logic [GAIN_W-1:0] down_o
);

    logic [GAIN_W:0]   sum;
    logic [GAIN_W-1:0] sat;

    // Extra carry bit lets the add saturate at full scale instead of wrapping.
    assign sum    = {1'b0, gain_i} + {1'b0, step_i};
    assign sat    = sum[GAIN_W] ? '1 : sum[GAIN_W-1:0];
    assign up_o   = (sat > target_i) ? target_i : sat;
    assign down_o = (gain_i > step_i) ? (gain_i - step_i) : '0;

endmodule

// File: rtl/rf_fade_controller.sv
// Gates transmitter gain and RF enable from the watchdog: attenuates on warning,
// fades to silence on trigger and stays muted until the latched fault is cleared.
module rf_fade_controller
    import am_radio_safety_pkg::*;
#(
    parameter int          GAIN_W     = GAIN_W_DEF,
    parameter int unsigned RAMP_STEP  = RAMP_STEP_DEF,
    parameter int unsigned RAMP_DIV   = RAMP_DIV_DEF,
    parameter int unsigned WARN_SHIFT = WARN_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [GAIN_W-1:0] gain_in,
    input  logic              wd_warning,
    input  logic              wd_triggered,
    input  logic              clear_fault,
    output logic [GAIN_W-1:0] gain_out,
    output logic              rf_enable,
    output logic              fault_latched,
    output logic [1:0]        state_out
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    fade_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              rf_en_q, rf_en_d;
    logic              fault_q, fault_d;

    logic [GAIN_W-1:0] target;
    logic [GAIN_W-1:0] up_gain, down_gain;
    logic              tick;
    logic              stop_req;

    assign target   = wd_warning ? (gain_in >> WARN_SHIFT) : gain_in;
    assign tick     = (cnt_q == CNT_W'(RAMP_DIV - 1));
    assign stop_req = wd_triggered || !enable;

    gain_ramp_step #(
        .GAIN_W   (GAIN_W)
    ) u_ramp_step (
        .gain_i   (gain_q),
        .target_i (target),
        .step_i   (STEP),
        .up_o     (up_gain),
        .down_o   (down_gain)
    );

    // A trigger in the same cycle as a clear keeps the fault set.
    always_comb begin
        fault_d = fault_q;
        if (wd_triggered) begin
            fault_d = 1'b1;
        end else if (clear_fault) begin
            fault_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        rf_en_d = rf_en_q;
        case (state_q)
            MUTED: begin
                gain_d  = '0;
                rf_en_d = 1'b0;
                if (enable && !wd_triggered && !fault_q) begin
                    state_d = RAMP_UP;
                    rf_en_d = 1'b1;
                end
            end
            RAMP_UP: begin
                rf_en_d = 1'b1;
                if (stop_req) begin
                    state_d = RAMP_DOWN;
                end else if (target < gain_q) begin
                    gain_d  = target;
                    state_d = RUN;
                end else if (tick) begin
                    gain_d = up_gain;
                    if (up_gain == target) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rf_en_d = 1'b1;
                if (stop_req) begin
                    state_d = RAMP_DOWN;
                end else begin
                    gain_d = target;
                end
            end
            RAMP_DOWN: begin
                // Ramp always runs to silence; enable and warning are ignored here.
                rf_en_d = 1'b1;
                if (tick) begin
                    gain_d = down_gain;
                    if (down_gain == '0) begin
                        state_d = MUTED;
                        rf_en_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = MUTED;
                gain_d  = '0;
                rf_en_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUTED;
            cnt_q   <= '0;
            gain_q  <= '0;
            rf_en_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gain_q  <= gain_d;
            rf_en_q <= rf_en_d;
            fault_q <= fault_d;
        end
    end

    assign gain_out      = gain_q;
    assign rf_enable     = rf_en_q;
    assign fault_latched = fault_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_rf_fade_controller.sv
// Directed walk through the fade scenarios followed by random traffic, all
// checked cycle by cycle against an arithmetic model of the fade rules.
module tb_rf_fade_controller;

    localparam int STEP = 'h1000;
    localparam int DIV  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] gain_in;
    logic        wd_warning;
    logic        wd_triggered;
    logic        clear_fault;
    logic [15:0] gain_out;
    logic        rf_enable;
    logic        fault_latched;
    logic [1:0]  state_out;

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0=muted 1=ramp up 2=run 3=ramp down; age = cycles spent in phase.
    int m_phase, m_gain, m_age;
    bit m_rf, m_fault;

    always #5 clk = ~clk;

    rf_fade_controller dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .gain_in       (gain_in),
        .wd_warning    (wd_warning),
        .wd_triggered  (wd_triggered),
        .clear_fault   (clear_fault),
        .gain_out      (gain_out),
        .rf_enable     (rf_enable),
        .fault_latched (fault_latched),
        .state_out     (state_out)
    );

    task automatic check_val(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock, evolving the model from the inputs present before the edge.
    task automatic cycle();
        int tgt, np, ng, na;
        bit nrf, nf, tick;
        tgt  = wd_warning ? (int'(gain_in) / 2) : int'(gain_in);
        tick = (m_age % DIV) == (DIV - 1);
        np = m_phase; ng = m_gain; nrf = m_rf;
        nf = wd_triggered ? 1'b1 : (clear_fault ? 1'b0 : m_fault);
        case (m_phase)
            0: begin
                ng = 0; nrf = 0;
                if (enable && !wd_triggered && !m_fault) begin np = 1; nrf = 1; end
            end
            1: begin
                nrf = 1;
                if (wd_triggered || !enable) np = 3;
                else if (tgt < m_gain) begin ng = tgt; np = 2; end
                else if (tick) begin
                    ng = (m_gain + STEP > tgt) ? tgt : m_gain + STEP;
                    if (ng == tgt) np = 2;
                end
            end
            2: begin
                nrf = 1;
                if (wd_triggered || !enable) np = 3;
                else ng = tgt;
            end
            default: begin
                nrf = 1;
                if (tick) begin
                    ng = (m_gain > STEP) ? m_gain - STEP : 0;
                    if (ng == 0) begin np = 0; nrf = 0; end
                end
            end
        endcase
        na = (np != m_phase) ? 0 : m_age + 1;
        if (rst) begin np = 0; ng = 0; nrf = 0; nf = 0; na = 0; end
        @(posedge clk);
        #1;
        m_phase = np; m_gain = ng; m_rf = nrf; m_fault = nf; m_age = na;
        check_val("gain_out", int'(gain_out), m_gain);
        check_val("rf_enable", int'(rf_enable), int'(m_rf));
        check_val("fault_latched", int'(fault_latched), int'(m_fault));
        check_val("state_out", int'(state_out), m_phase);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        int budget;
        rst = 1'b1; enable = 1'b0; gain_in = '0;
        wd_warning = 1'b0; wd_triggered = 1'b0; clear_fault = 1'b0;
        m_phase = 0; m_gain = 0; m_age = 0; m_rf = 0; m_fault = 0;
        do_reset();
        check_val("reset_state", int'(state_out), 0);
        check_val("reset_gain", int'(gain_out), 0);

        // Soft start: one cycle to leave MUTED, then 8 ticks of 4 cycles.
        enable = 1'b1; gain_in = 16'h8000;
        run(33);
        check_val("soft_start_gain", int'(gain_out), 'h8000);
        check_val("soft_start_state", int'(state_out), 2);
        $display("soft start: gain 0x%0h state %0d", gain_out, state_out);

        wd_warning = 1'b1; run(1);
        check_val("warn_atten", int'(gain_out), 'h4000);
        wd_warning = 1'b0; run(1);
        check_val("warn_release", int'(gain_out), 'h8000);
        $display("warning: gain restored to 0x%0h", gain_out);

        wd_triggered = 1'b1; run(1);
        wd_triggered = 1'b0;
        check_val("trig_fault", int'(fault_latched), 1);
        run(32);
        check_val("fade_gain", int'(gain_out), 0);
        check_val("fade_state", int'(state_out), 0);
        check_val("fade_rf", int'(rf_enable), 0);
        run(5);
        check_val("stay_muted", int'(state_out), 0);
        $display("trigger fade: state %0d fault %0d", state_out, fault_latched);

        clear_fault = 1'b1; wd_triggered = 1'b1; run(1);
        check_val("clear_vs_trig", int'(fault_latched), 1);
        wd_triggered = 1'b0; run(1);
        clear_fault = 1'b0;
        check_val("clear_fault", int'(fault_latched), 0);
        run(1);
        check_val("restart_ramp", int'(state_out), 1);
        $display("fault clear: fault %0d state %0d", fault_latched, state_out);

        gain_in = 16'hFFFF;
        run(70);
        check_val("sat_gain", int'(gain_out), 'hFFFF);
        check_val("sat_state", int'(state_out), 2);
        $display("saturation: gain 0x%0h", gain_out);

        do_reset();
        gain_in = 16'h8000;
        budget = 0;
        while (gain_out != 16'h3000 && budget < 100) begin cycle(); budget++; end
        check_val("reach_3000_timeout", int'(budget < 100), 1);
        enable = 1'b0;
        run(13);
        check_val("abort_gain", int'(gain_out), 0);
        check_val("abort_state", int'(state_out), 0);
        $display("enable drop mid ramp: state %0d", state_out);

        enable = 1'b1; run(10);
        rst = 1'b1; run(1); rst = 1'b0;
        check_val("midramp_rst_gain", int'(gain_out), 0);
        check_val("midramp_rst_state", int'(state_out), 0);
        $display("reset mid ramp: state %0d", state_out);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 5) begin
                case ($urandom_range(3))
                    0: gain_in = 16'hFFFF;
                    1: gain_in = 16'(STEP * $urandom_range(16));
                    default: gain_in = 16'($urandom);
                endcase
            end
            if ($urandom_range(99) < 3) enable = ~enable;
            wd_warning   = ($urandom_range(99) < 15);
            wd_triggered = ($urandom_range(199) < 2);
            clear_fault  = ($urandom_range(99) < 6);
            rst          = ($urandom_range(499) < 1);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
